// File: rtl/nic_pkg.sv
// Shared packet-ring definitions for the rf68000 NIC: packet layout, type codes and node ids.
package nic_pkg;

  localparam logic [5:0] NODE_GLOBAL = 6'd62;
  localparam logic [5:0] NODE_BCAST  = 6'd63;

  typedef enum logic [3:0] {
    PT_NULL  = 4'd0,
    PT_READ  = 4'd1,
    PT_WRITE = 4'd2,
    PT_AREAD = 4'd3,
    PT_ACK   = 4'd4,
    PT_AACK  = 4'd5,
    PT_ERR   = 4'd6,
    PT_VPA   = 4'd7
  } ptype_t;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [3:0]  age;
    logic        ack;
    ptype_t      typ;
    logic [7:0]  asid;
    logic        mmus;
    logic        ios;
    logic        iops;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } gstate_t;

  function automatic logic is_request(input ptype_t t);
    return (t == PT_READ) || (t == PT_AREAD) || (t == PT_WRITE);
  endfunction

endpackage

// File: rtl/rf68000_req_fifo.sv
// Request queue for the global server: packet_t entries with a show-ahead head,
// registered pointers and an occupancy count.
module rf68000_req_fifo import nic_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  packet_t                din,
  output packet_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  packet_t        mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  // A pop on a full queue frees the slot the simultaneous push writes into.
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf68000_ring_gserver.sv
// Global-resource responder on the rf68000 packet ring: captures requests addressed to
// NODE_ID, runs them one at a time on the global bus and returns responses on the rpacket ring.
module rf68000_ring_gserver import nic_pkg::*; #(
  parameter logic [5:0] NODE_ID    = NODE_GLOBAL,
  parameter int         FIFO_DEPTH = 8,
  parameter bit         SYNC_WRITE = 1'b1,
  parameter int         TO_BIT     = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  packet_t     packet_i,
  output packet_t     packet_o,
  input  packet_t     rpacket_i,
  output packet_t     rpacket_o,
  output logic [5:0]  m_core_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [7:0]  m_asid_o,
  output logic        m_mmus_o,
  output logic        m_ios_o,
  output logic        m_iops_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_vpa_i,
  input  logic [31:0] m_dat_i,
  output logic        busy_o
);

  gstate_t                     state;
  ptype_t                      cur_typ;
  logic [TO_BIT:0]             to_cnt;
  packet_t                     resp_buf;
  logic                        resp_valid;
  packet_t                     resp_next;
  packet_t                     head;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        addressed;
  logic                        is_req;
  logic                        push;
  logic                        pop;
  logic                        term;
  logic                        unused_head;

  assign addressed = (packet_i.did == NODE_ID);
  assign is_req    = is_request(packet_i.typ);
  assign push      = addressed && is_req && !full;
  assign pop       = (state == ST_IDLE) && !empty && !resp_valid;
  assign term      = m_ack_i || m_err_i || m_vpa_i || to_cnt[TO_BIT];
  assign busy_o    = (count != '0) || (state != ST_IDLE) || resp_valid;

  assign unused_head = &{1'b0, head.did, head.age, head.ack};

  rf68000_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (packet_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Slot is freed for captured requests and for non-request traffic to this node;
  // a request that finds the queue full keeps circulating untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      packet_o <= '0;
    end else begin
      packet_o <= packet_i;
      if (addressed && (push || !is_req)) begin
        packet_o.did <= '0;
        packet_o.sid <= '0;
      end
    end
  end

  // Response is built from the still-registered bus qualifiers at the terminating edge.
  always_comb begin
    resp_next      = '0;
    resp_next.did  = m_core_o;
    resp_next.sid  = NODE_ID;
    resp_next.ack  = 1'b1;
    resp_next.asid = m_asid_o;
    resp_next.mmus = m_mmus_o;
    resp_next.ios  = m_ios_o;
    resp_next.iops = m_iops_o;
    resp_next.adr  = m_adr_o;
    resp_next.dat  = m_dat_i;
    if (m_ack_i) begin
      resp_next.typ = (cur_typ == PT_AREAD) ? PT_AACK : PT_ACK;
    end else if (m_err_i) begin
      resp_next.typ = PT_ERR;
    end else if (m_vpa_i) begin
      resp_next.typ = PT_VPA;
    end else begin
      resp_next.typ = PT_ERR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cur_typ    <= PT_NULL;
      to_cnt     <= '0;
      resp_buf   <= '0;
      resp_valid <= 1'b0;
      rpacket_o  <= '0;
      m_core_o   <= '0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_sel_o    <= '0;
      m_asid_o   <= '0;
      m_mmus_o   <= 1'b0;
      m_ios_o    <= 1'b0;
      m_iops_o   <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
    end else begin
      rpacket_o <= rpacket_i;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_typ  <= head.typ;
            m_core_o <= head.sid;
            m_cyc_o  <= 1'b1;
            m_stb_o  <= 1'b1;
            m_we_o   <= (head.typ == PT_WRITE);
            m_sel_o  <= (head.typ == PT_WRITE) ? head.sel : 4'hF;
            m_asid_o <= head.asid;
            m_mmus_o <= head.mmus;
            m_ios_o  <= head.ios;
            m_iops_o <= head.iops;
            m_adr_o  <= head.adr;
            m_dat_o  <= head.dat;
            to_cnt   <= '0;
            state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (term) begin
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            m_we_o   <= 1'b0;
            m_sel_o  <= '0;
            m_asid_o <= '0;
            m_mmus_o <= 1'b0;
            m_ios_o  <= 1'b0;
            m_iops_o <= 1'b0;
            if ((cur_typ == PT_WRITE) && !SYNC_WRITE) begin
              state <= ST_IDLE;
            end else begin
              resp_buf   <= resp_next;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rpacket_i.did == '0) begin
            rpacket_o  <= resp_buf;
            resp_buf   <= '0;
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
